// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: deserializes 5-bit frames (a,b,c,d,p) from a serial line
// and runs each frame through the parity checker. The data nibble and the error
// verdict are registered and offered downstream over a valid/ready handshake.
// The block also keeps a saturating error count and a sticky alarm that is set
// by a run of consecutive bad frames.

// Team 4-bit parity checker: e = 1 flags an even-parity error over five bits.
module boolean (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic p,
  output logic e
);
  assign e = a ^ b ^ c ^ d ^ p;
endmodule

module parity_frame_ctrl #(
  parameter int ERR_CNT_W    = 8,
  parameter int ALARM_THRESH = 3   // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdi,
  input  logic                 out_ready,
  input  logic                 clr_count,
  output logic                 busy,
  output logic                 out_valid,
  output logic [3:0]           out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 alarm
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [3:0]           THRESH    = 4'(ALARM_THRESH);
  localparam logic [3:0]           CONSEC_MX = 4'hF;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

  state_t               state_q,   state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [4:0]           frame_q,   frame_d;
  logic [3:0]           data_q,    data_d;
  logic                 err_q,     err_d;
  logic [ERR_CNT_W-1:0] cnt_q,     cnt_d;
  logic [3:0]           consec_q,  consec_d;
  logic                 alarm_q,   alarm_d;
  logic                 chk_e;

  // The checker always looks at the frame register; its result is only
  // captured in CHECK, once all five bits are in place.
  boolean u_chk (
    .a (frame_q[0]),
    .b (frame_q[1]),
    .c (frame_q[2]),
    .d (frame_q[3]),
    .p (frame_q[4]),
    .e (chk_e)
  );

  // Next-state logic for the frame sequencer, result registers and counters.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    consec_d  = consec_q;
    alarm_d   = alarm_q;

    case (state_q)
      IDLE: begin
        // sdi in the start cycle is not part of the frame.
        if (start) begin
          state_d   = SHIFT;
          bit_idx_d = 3'd0;
        end
      end
      SHIFT: begin
        frame_d[bit_idx_q] = sdi;
        if (bit_idx_q == 3'd4) begin
          state_d   = CHECK;
          bit_idx_d = 3'd0;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      CHECK: begin
        data_d = frame_q[3:0];
        err_d  = chk_e;
        if (chk_e) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + ERR_CNT_W'(1);
          if (consec_q != CONSEC_MX) consec_d = consec_q + 4'd1;
        end else begin
          consec_d = 4'd0;
        end
        state_d = REPORT;
      end
      REPORT: begin
        // Result is held until downstream takes it; start is not queued.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Sticky: once the run length reaches the threshold only a clear drops it.
    if (consec_d >= THRESH) alarm_d = 1'b1;

    // A clear overrides any increment made in the same cycle.
    if (clr_count) begin
      cnt_d    = '0;
      consec_d = 4'd0;
      alarm_d  = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      frame_q   <= 5'd0;
      data_q    <= 4'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      consec_q  <= 4'd0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      consec_q  <= consec_d;
      alarm_q   <= alarm_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == REPORT);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl: a table of frames with hand-computed
// results, followed by hand-written backpressure, clear-priority and
// mid-frame reset sequences.
module tb_parity_frame_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sdi;
  logic          out_ready;
  logic          clr_count;
  logic          busy;
  logic          out_valid;
  logic [3:0]    out_data;
  logic          out_err;
  logic [CW-1:0] err_count;
  logic          alarm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.ERR_CNT_W(CW), .ALARM_THRESH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sdi       (sdi),
    .out_ready (out_ready),
    .clr_count (clr_count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count),
    .alarm     (alarm)
  );

  // seq is written in transmission order: seq[0]=a ... seq[4]=p.
  typedef struct {
    logic       clr_before;
    logic [0:4] seq;
    logic [3:0] exp_data;
    logic       exp_err;
    int         exp_cnt;
    logic       exp_alarm;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enters at cycle 0 (IDLE), leaves at cycle 6 (CHECK) with inputs free.
  task automatic send_frame(input logic [0:4] seq);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdi = seq[i];
      if (i == 0) chk("busy_shift", int'(busy), 1);
      step();
    end
    sdi = 1'b0;
    chk("valid_in_check", int'(out_valid), 0);
  endtask

  task automatic pulse_clear();
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("clr_count", int'(err_count), 0);
    chk("clr_alarm", int'(alarm), 0);
  endtask

  initial begin
    //                clr   a..p       data     err  cnt alarm
    vecs[0]  = '{1'b0, 5'b10111, 4'b1101, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 5'b10000, 4'b0001, 1'b1, 1, 1'b0};
    vecs[2]  = '{1'b0, 5'b01100, 4'b0110, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 5'b11100, 4'b0111, 1'b1, 2, 1'b0};
    vecs[4]  = '{1'b0, 5'b00001, 4'b0000, 1'b1, 3, 1'b0};
    vecs[5]  = '{1'b0, 5'b11110, 4'b1111, 1'b0, 3, 1'b0};
    vecs[6]  = '{1'b1, 5'b10000, 4'b0001, 1'b1, 1, 1'b0};
    vecs[7]  = '{1'b0, 5'b01000, 4'b0010, 1'b1, 2, 1'b0};
    vecs[8]  = '{1'b0, 5'b00100, 4'b0100, 1'b1, 3, 1'b1};
    vecs[9]  = '{1'b0, 5'b00000, 4'b0000, 1'b0, 3, 1'b1};
    vecs[10] = '{1'b0, 5'b00010, 4'b1000, 1'b1, 3, 1'b1};
    vecs[11] = '{1'b1, 5'b11000, 4'b0011, 1'b0, 0, 1'b0};

    rst_n = 1'b0; start = 1'b0; sdi = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    step();
    step();
    chk("rst_busy",  int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  int'(out_data), 0);
    chk("rst_err",   int'(out_err), 0);
    chk("rst_cnt",   int'(err_count), 0);
    chk("rst_alarm", int'(alarm), 0);
    rst_n = 1'b1;
    step();

    // Table: each frame with out_ready held high.
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr_before) pulse_clear();
      send_frame(vecs[v].seq);
      if (v == 8) chk("alarm_before_c7", int'(alarm), 0);
      step();  // cycle 7
      chk("valid_c7", int'(out_valid), 1);
      chk("data_c7",  int'(out_data), int'(vecs[v].exp_data));
      chk("err_c7",   int'(out_err), int'(vecs[v].exp_err));
      chk("cnt_c7",   int'(err_count), vecs[v].exp_cnt);
      chk("alarm_c7", int'(alarm), int'(vecs[v].exp_alarm));
      step();  // cycle 8
      chk("busy_c8",  int'(busy), 0);
      chk("valid_c8", int'(out_valid), 0);
      $display("[TB] frame %0d seq=%b data=%b err=%0d cnt=%0d alarm=%0d",
               v, vecs[v].seq, out_data, out_err, err_count, alarm);
    end

    // Backpressure: result held 10 cycles while start and sdi wiggle.
    out_ready = 1'b0;
    send_frame(5'b10000);
    step();  // cycle 7
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data",  int'(out_data), 4'b0001);
      chk("bp_err",   int'(out_err), 1);
      chk("bp_busy",  int'(busy), 1);
      start = i[0];
      sdi   = ~i[0];
      step();
    end
    start = 1'b0; sdi = 1'b0;
    chk("bp_valid_hold", int'(out_valid), 1);
    chk("bp_cnt", int'(err_count), 1);
    out_ready = 1'b1;
    step();
    chk("bp_valid_drop", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_queued_start", int'(busy), 0);
      step();
    end
    $display("[TB] backpressure frame data=%b err=%0d cnt=%0d", out_data, out_err, err_count);

    // Clear coinciding with the CHECK increment: clear wins.
    send_frame(5'b10000);
    clr_count = 1'b1;
    step();  // cycle 7
    clr_count = 1'b0;
    chk("clrprio_cnt",   int'(err_count), 0);
    chk("clrprio_alarm", int'(alarm), 0);
    chk("clrprio_data",  int'(out_data), 4'b0001);
    chk("clrprio_err",   int'(out_err), 1);
    step();
    $display("[TB] clear-in-check cnt=%0d", err_count);

    // Reset after three bits, then a clean frame.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdi = 1'b1;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data",  int'(out_data), 0);
    chk("midrst_err",   int'(out_err), 0);
    step();
    rst_n = 1'b1; sdi = 1'b0;
    step();
    send_frame(5'b00011);  // a=0 b=0 c=0 d=1 p=1 -> good
    step();
    chk("postrst_valid", int'(out_valid), 1);
    chk("postrst_data",  int'(out_data), 4'b1000);
    chk("postrst_err",   int'(out_err), 0);
    chk("postrst_cnt",   int'(err_count), 0);
    step();
    $display("[TB] post-reset frame data=%b err=%0d", out_data, out_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Sequencer wrapped around the team's 4-bit parity checker, `boolean`, which has inputs a, b, c, d, p and output e = a^b^c^d^p. The block:

- deserializes 5-bit frames from a serial line,
- presents each frame to the checker,
- registers the data nibble and the error verdict, and hands the result downstream over a valid/ready handshake,
- keeps a saturating error count and a sticky alarm for consecutive bad frames.

It sits between the serial receive path and the status/host logic.

## Interface
- ERR_CNT_W, 8, width of the saturating error counter
- ALARM_THRESH, 3, consecutive-error count that sets alarm (legal range 1..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start strobe; sampled only in IDLE
- sdi  in  1  serial data; one bit per cycle, order a, b, c, d, p
- out_ready  in  1  downstream accepts result
- clr_count  in  1  synchronous clear of err_count, consecutive-error count and alarm
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  result available
- out_data  out  4  {d,c,b,a} of the last frame
- out_err  out  1  checker e for the last frame; 1 = parity error (even parity over 5 bits)
- err_count  out  ERR_CNT_W  number of errored frames, saturating at all-ones
- alarm  out  1  sticky: set when consecutive errors reach ALARM_THRESH

## Operation
- FSM states: IDLE, SHIFT, CHECK, REPORT.
- **IDLE:**
  - start=1 → SHIFT; clear the bit index to 0.
  - sdi is ignored in the start cycle.
- **SHIFT:**
  - Each cycle, shift sdi into the frame register at the current index (0=a … 4=p).
  - After index 4 is captured → CHECK.
- **CHECK (one cycle):**
  - Drive the checker from the frame register.
  - Register out_data <= {d,c,b,a} and out_err <= e.
  - If e=1: err_count += 1 unless already all-ones; consec += 1 (saturating at 15).
  - If e=0: consec <= 0.
  - Go to REPORT.
- **Alarm:** set on the cycle consec reaches ALARM_THRESH. It stays set until clr_count or reset; a later good frame does not clear it.
- **REPORT:**
  - out_valid=1. out_data and out_err stay stable until the transfer (out_valid & out_ready).
  - On transfer → IDLE and out_valid drops.
- start is ignored in SHIFT, CHECK and REPORT; it is not queued.
- **clr_count:**
  - Takes effect in any state.
  - If it coincides with a CHECK-state increment, clear wins: err_count=0, consec=0, alarm=0.
  - It does not affect the FSM or out_data/out_err.
- **Async reset (rst_n=0):**
  - Immediate return to IDLE; a partially shifted frame is discarded.
  - Outputs: busy=0, out_valid=0, out_data=0, out_err=0, err_count=0, alarm=0. Internal consec=0, bit index=0.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1–5: SHIFT; bits a, b, c, d, p are sampled at the rising edges ending cycles 1..5.
- Cycle 6: CHECK.
- Cycle 7: out_valid first high, with out_data/out_err valid. err_count and alarm update on the edge ending cycle 6, so they are visible from cycle 7.
- With out_ready held high: transfer in cycle 7, IDLE in cycle 8, next start sampled no earlier than cycle 8. Minimum frame period is 8 cycles.
- busy is high from cycle 1 through the transfer cycle inclusive.
- out_ready low holds REPORT indefinitely; sdi activity during REPORT is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Good frame:** reset, then start; sdi=1,0,1,1,1 (a..p) with out_ready=1. Required: out_valid at cycle 7; out_data=4'b1101, out_err=0, err_count=0; busy low in cycle 8.
- **Bad frame:** sdi=1,0,0,0,0. Required: out_data=4'b0001, out_err=1, err_count=1, alarm=0.
- **Backpressure:** out_ready=0 for 10 cycles after out_valid, with start pulsed and sdi toggling during the wait. Required: outputs stable and a single transfer when out_ready rises. No new frame is started until start is seen again in IDLE.
- **Alarm:** three consecutive bad frames, then one good frame. Required: alarm rises at cycle 7 of frame 3 and remains 1 after the good frame; err_count=3. Then clr_count=1 for one cycle gives err_count=0, alarm=0.
- **Saturation and clear priority:**
  - With ERR_CNT_W=2, four bad frames leave err_count=3.
  - clr_count asserted in the CHECK cycle of a bad frame leaves err_count=0.
- **Reset mid-frame:** rst_n low after 3 bits shifted. Required: busy=0 and out_valid=0 immediately. A following full good frame then reports the correct data, unaffected by the partial bits.
